// File: rtl/fpadd_wb_pkg.sv
// Shared types and constants for the fpadd writeback stage.
// Optional build macro: FPADD_WB_CANON_NAN_EN (canonicalise NaN results on wb_data).
package fpadd_wb_pkg;

    // Bit positions inside the 5-bit exception flag vector {NV,DZ,OF,UF,NX}
    localparam int NV = 4;
    localparam int DZ = 3;
    localparam int OF = 2;
    localparam int UF = 1;
    localparam int NX = 0;

    // One buffered fpadd result
    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  flags;
        logic        p;
        logic [4:0]  rd;
    } wb_entry_t;

    // Canonical quiet NaNs as they appear on the 64-bit write port
    localparam logic [63:0] CANON_NAN_S = 64'hFFFF_FFFF_7FC0_0000;
    localparam logic [63:0] CANON_NAN_D = 64'h7FF8_0000_0000_0000;

    // Single-precision values are NaN-boxed into the upper-ones pattern
    function automatic logic [63:0] nan_box(input logic [63:0] v, input logic p);
        logic [63:0] r;
        if (p) begin
            r = {32'hFFFF_FFFF, v[63:32]};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // NaN detection: exponent all ones with a nonzero mantissa
    function automatic logic is_nan(input logic [63:0] v, input logic p);
        logic r;
        if (p) begin
            r = (v[62:55] == 8'hFF) && (v[54:32] != 23'h0);
        end else begin
            r = (v[62:52] == 11'h7FF) && (v[51:0] != 52'h0);
        end
        return r;
    endfunction

endpackage

// File: rtl/fpadd_wb_fifo.sv
// DEPTH-entry FIFO of wb_entry_t. The occupancy counter is the single
// source of truth for full/empty; pointers simply wrap modulo DEPTH.
module fpadd_wb_fifo
    import fpadd_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  wb_entry_t     wdata,
    output wb_entry_t     rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    wb_entry_t         mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       count_r;

    // Pointer and occupancy bookkeeping; reset discards all entries
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are meaningless while the slot is unoccupied
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == (AW+1)'(DEPTH));
    assign empty = (count_r == (AW+1)'(0));

endmodule

// File: rtl/fpadd_wb.sv
// Writeback stage behind fpadd: buffers results, drains them to the FP
// register-file write port with NaN-boxing, and keeps the sticky fflags.
// Optional build macro: FPADD_WB_CANON_NAN_EN replaces NaN results on
// wb_data by the canonical NaN of the result's precision.
module fpadd_wb
    import fpadd_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_result,
    input  logic [4:0]    in_flags,
    input  logic          in_p,
    input  logic [4:0]    in_rd,
    output logic          wb_valid,
    input  logic          wb_ready,
    output logic [63:0]   wb_data,
    output logic [4:0]    wb_rd,
    output logic [4:0]    fflags,
    input  logic          fflags_wr,
    input  logic [4:0]    fflags_wdata,
    output logic [AW:0]   count
);

    wb_entry_t   in_entry_s;
    wb_entry_t   head_s;
    logic        full_s;
    logic        empty_s;
    logic        push_s;
    logic        pop_s;
    logic [63:0] data_s;
    logic [4:0]  rd_s;
    logic [4:0]  fflags_r;

    // A full FIFO refuses pushes even when a pop happens in the same cycle
    assign push_s     = in_valid && !full_s;
    assign pop_s      = !empty_s && wb_ready;
    assign in_entry_s = '{result: in_result, flags: in_flags, p: in_p, rd: in_rd};

    fpadd_wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (in_entry_s),
        .rdata (head_s),
        .count (count),
        .full  (full_s),
        .empty (empty_s)
    );

    // Format the head entry for the register file; outputs read 0 when empty
    always_comb begin
        data_s = 64'h0;
        rd_s   = 5'd0;
        if (!empty_s) begin
            data_s = nan_box(head_s.result, head_s.p);
            rd_s   = head_s.rd;
`ifdef FPADD_WB_CANON_NAN_EN
            if (is_nan(head_s.result, head_s.p)) begin
                if (head_s.p) begin
                    data_s = CANON_NAN_S;
                end else begin
                    data_s = CANON_NAN_D;
                end
            end else begin
                data_s = nan_box(head_s.result, head_s.p);
            end
`endif
        end else begin
            data_s = 64'h0;
            rd_s   = 5'd0;
        end
    end

    // Sticky flags: a CSR write lands first, then the committing entry ORs in
    always_ff @(posedge clk) begin
        if (!reset) begin
            fflags_r <= 5'b0;
        end else begin
            fflags_r <= (fflags_wr ? fflags_wdata : fflags_r) |
                        (pop_s ? head_s.flags : 5'b0);
        end
    end

    assign in_ready = !full_s;
    assign wb_valid = !empty_s;
    assign wb_data  = data_s;
    assign wb_rd    = rd_s;
    assign fflags   = fflags_r;

endmodule

// File: tb/tb_fpadd_wb.sv
// Self-checking bench for fpadd_wb: directed steps followed by random traffic,
// compared against a queue-based reference model of the writeback stage.
module tb_fpadd_wb;

    localparam int DEPTH = 2;
    localparam int AW    = 1;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_result;
    logic [4:0]    in_flags;
    logic          in_p;
    logic [4:0]    in_rd;
    logic          wb_valid;
    logic          wb_ready;
    logic [63:0]   wb_data;
    logic [4:0]    wb_rd;
    logic [4:0]    fflags;
    logic          fflags_wr;
    logic [4:0]    fflags_wdata;
    logic [AW:0]   count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  fl;
        logic        p;
        logic [4:0]  rd;
    } ent_t;

    ent_t       mq[$];
    logic [4:0] mf;

    fpadd_wb #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_flags     (in_flags),
        .in_p         (in_p),
        .in_rd        (in_rd),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .fflags       (fflags),
        .fflags_wr    (fflags_wr),
        .fflags_wdata (fflags_wdata),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected register-file data for a buffered result
    function automatic logic [63:0] fmt(input ent_t e);
        logic [31:0] s;
        logic [63:0] r;
        s = e.res[63:32];
        if (e.p) r = {32'hFFFF_FFFF, s};
        else     r = e.res;
`ifdef FPADD_WB_CANON_NAN_EN
        if (e.p && ((s >> 23) & 32'hFF) == 32'hFF && (s & 32'h007F_FFFF) != 32'h0)
            r = 64'hFFFF_FFFF_7FC0_0000;
        if (!e.p && ((e.res >> 52) & 64'h7FF) == 64'h7FF &&
            (e.res & ((64'h1 << 52) - 64'h1)) != 64'h0)
            r = 64'h7FF8_0000_0000_0000;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".wb_valid"}, 64'(wb_valid), 64'(mq.size() != 0));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(mq.size() < DEPTH));
        chk({tag, ".count"},    64'(count),    64'(mq.size()));
        chk({tag, ".fflags"},   64'(fflags),   64'(mf));
        if (mq.size() != 0) begin
            chk({tag, ".wb_data"}, wb_data, fmt(mq[0]));
            chk({tag, ".wb_rd"},   64'(wb_rd), 64'(mq[0].rd));
        end else begin
            chk({tag, ".wb_data0"}, wb_data, 64'h0);
            chk({tag, ".wb_rd0"},   64'(wb_rd), 64'h0);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] res, input logic [4:0] fl,
                         input logic p, input logic [4:0] rd, input logic rdy,
                         input logic fw, input logic [4:0] fwd);
        in_valid     = v;
        in_result    = res;
        in_flags     = fl;
        in_p         = p;
        in_rd        = rd;
        wb_ready     = rdy;
        fflags_wr    = fw;
        fflags_wdata = fwd;
    endtask

    // Advance one clock, updating the reference model from the applied inputs
    task automatic tick();
        bit do_push;
        bit do_pop;
        do_push = in_valid && (mq.size() < DEPTH);
        do_pop  = (mq.size() != 0) && wb_ready;
        @(posedge clk);
        if (!reset) begin
            mq.delete();
            mf = 5'b0;
        end else begin
            mf = (fflags_wr ? fflags_wdata : mf) | (do_pop ? mq[0].fl : 5'b0);
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back('{in_result, in_flags, in_p, in_rd});
        end
        #1;
    endtask

    initial begin
        logic [63:0] res;
        mf = 5'b0;
        reset = 1'b0;
        drive(1'b0, 64'h0, 5'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'b0);
        #1;
        tick();
        tick();
        check_all("reset");
        reset = 1'b1;

        // single push of 3.0f
        drive(1'b1, {32'h4040_0000, 32'h0}, 5'b0, 1'b1, 5'd3, 1'b1, 1'b0, 5'b0);
        tick();
        check_all("single");
        chk("single.data_const", wb_data, 64'hFFFF_FFFF_4040_0000);
        drive(1'b0, 64'h0, 5'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'b0);
        tick();
        check_all("single_after");
        chk("single_after.valid_const", 64'(wb_valid), 64'h0);

        // backpressure: three pushes with the register file stalled
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, {32'h3F80_0000 + 32'(i), 32'h1234_0000 + 32'(i)}, 5'(i), 1'(i & 1),
                  5'(10 + i), 1'b0, 1'b0, 5'b0);
            tick();
            check_all("bp_push");
        end
        chk("bp.count_full", 64'(count), 64'd2);
        chk("bp.ready_low",  64'(in_ready), 64'd0);
        chk("bp.fflags",     64'(fflags), 64'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 64'h0, 5'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'b0);
            tick();
            check_all("bp_drain");
        end

        // sticky flags and CSR write/commit collision
        drive(1'b1, 64'h0, 5'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'b0);
        tick();
        drive(1'b1, 64'h1, 5'b00001, 1'b0, 5'd1, 1'b1, 1'b0, 5'b0);
        tick();
        drive(1'b1, 64'h2, 5'b10000, 1'b0, 5'd2, 1'b1, 1'b0, 5'b0);
        tick();
        drive(1'b0, 64'h0, 5'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'b0);
        tick();
        check_all("sticky");
        chk("sticky.const", 64'(fflags), 64'(5'b10001));
        drive(1'b1, 64'h3, 5'b00100, 1'b0, 5'd4, 1'b0, 1'b0, 5'b0);
        tick();
        drive(1'b0, 64'h0, 5'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'b00000);
        tick();
        check_all("csr_commit");
        chk("csr_commit.const", 64'(fflags), 64'(5'b00100));

        // pointer wrap with back-to-back push/pop
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, {32'(i), 32'(i)}, 5'b0, 1'b0, 5'(i), 1'b1, 1'b0, 5'b0);
            tick();
            check_all("wrap");
            chk("wrap.rd_const", 64'(wb_rd), 64'(i));
            chk("wrap.count1", 64'(count), 64'd1);
        end
        drive(1'b0, 64'h0, 5'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'b0);
        tick();
        check_all("wrap_end");

        // reset while full with pending flags
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 64'h5, 5'b01000, 1'b0, 5'd7, 1'b0, 1'b0, 5'b0);
            tick();
        end
        check_all("pre_reset");
        drive(1'b0, 64'h0, 5'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'b0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_all("mid_reset");
        chk("mid_reset.count",  64'(count), 64'd0);
        chk("mid_reset.fflags", 64'(fflags), 64'd0);
        chk("mid_reset.ready",  64'(in_ready), 64'd1);

        // NaN handling
        drive(1'b1, {32'h7FA0_0001, 32'h0}, 5'b0, 1'b1, 5'd5, 1'b0, 1'b0, 5'b0);
        tick();
        check_all("nan_s");
`ifdef FPADD_WB_CANON_NAN_EN
        chk("nan_s.const", wb_data, 64'hFFFF_FFFF_7FC0_0000);
`else
        chk("nan_s.const", wb_data, 64'hFFFF_FFFF_7FA0_0001);
`endif
        drive(1'b0, 64'h0, 5'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'b0);
        tick();
        drive(1'b1, 64'hFFF0_0000_0000_0001, 5'b0, 1'b0, 5'd6, 1'b0, 1'b0, 5'b0);
        tick();
        check_all("nan_d");
`ifdef FPADD_WB_CANON_NAN_EN
        chk("nan_d.const", wb_data, 64'h7FF8_0000_0000_0000);
`else
        chk("nan_d.const", wb_data, 64'hFFF0_0000_0000_0001);
`endif
        drive(1'b0, 64'h0, 5'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'b0);
        tick();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       res = {32'h7F80_0000 | 32'($urandom_range(1, 255)), $urandom};
                1:       res = {32'hFFF0_0000 | 32'($urandom_range(0, 15)), $urandom};
                default: res = {$urandom, $urandom};
            endcase
            drive(1'($urandom_range(0, 1)), res, 5'($urandom), 1'($urandom_range(0, 1)),
                  5'($urandom), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 7) == 0), 5'($urandom));
            reset = ($urandom_range(0, 49) != 0);
            tick();
            check_all("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpadd_wb.md
Name: fpadd_wb

Overview:
Writeback stage directly downstream of fpadd. Accepts each fpadd result with its 5 exception flags and destination register, and buffers it in a small FIFO. Drains entries to the FP register-file write port over a valid/ready handshake, NaN-boxing single-precision results. Maintains the sticky fflags accumulator, which is updated when each result is committed.

Parameters:
DEPTH, 2, FIFO entries; power of two, minimum 2.
AW, 1, pointer width; equals log2(DEPTH).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
in_valid  in  1  fpadd result valid
in_ready  out  1  stage can accept; equals !full
in_result  in  64  fpadd result; f32 value occupies [63:32] when in_p=1
in_flags  in  5  fpadd Flags, ordered {NV,DZ,OF,UF,NX}
in_p  in  1  1 = single precision, 0 = double
in_rd  in  5  destination FP register
wb_valid  out  1  head entry valid
wb_ready  in  1  register file accepts
wb_data  out  64  writeback data
wb_rd  out  5  writeback register
fflags  out  5  sticky accumulated flags
fflags_wr  in  1  CSR write of fflags
fflags_wdata  in  5  CSR write data
count  out  AW+1  occupied entries

Behaviour:
- Reset (reset==0 at posedge): pointers and count go to 0, fflags=0, wb_valid=0. wb_data and wb_rd read 0 whenever the FIFO is empty.
- Push: occurs when in_valid && in_ready. Stores {result, flags, p, rd} at the write pointer.
- Pop: occurs when wb_valid && wb_ready. Advances the read pointer.
- Latency: an entry pushed in cycle N is presented on wb_* in cycle N+1. There is no same-cycle bypass.
- Full (count==DEPTH): in_ready=0. A simultaneous pop does not enable a push in that cycle.
- Empty: a push-only cycle raises count. A pop is impossible because wb_valid=0.
- Simultaneous push and pop when neither full nor empty: count is unchanged and both pointers advance.
- Pointers are AW bits and wrap modulo DEPTH. count is the authoritative full/empty indicator.
- wb_data formatting:
  - p=1: {32'hFFFF_FFFF, result[63:32]} (NaN-box).
  - p=0: result unchanged.
- wb_rd comes from the head entry.
- fflags update at posedge, in one rule: fflags_next = (fflags_wr ? fflags_wdata : fflags) | (pop ? head.flags : 5'b0).
  - A CSR write and a commit in the same cycle: the write lands, then that commit's flags are ORed in.
  - Flags of entries still in the FIFO are never visible in fflags.
- wb_data, wb_rd and wb_valid hold stable while wb_valid && !wb_ready. The FIFO head does not change without a pop.
- Reset asserted mid-operation: all buffered entries are discarded and their flags are never accumulated.
- in_result is not inspected for width legality. Upper 32 bits of double results are passed verbatim.

Optional Feature:
Macro FPADD_WB_CANON_NAN_EN.
- Defined: a NaN result is replaced on wb_data by the canonical NaN.
  - NaN test, single: exponent [62:55] all ones and mantissa [54:32] nonzero.
  - NaN test, double: exponent [62:52] all ones and mantissa nonzero.
  - Replacement, single: FFFF_FFFF_7FC0_0000.
  - Replacement, double: 7FF8_0000_0000_0000.
  - Flags are unaffected.
- Not defined: NaN payload and sign pass through, with NaN-boxing only.

Decomposition:
- Package fpadd_wb_pkg holds:
  - the flag bit-index constants NV=4, DZ=3, OF=2, UF=1, NX=0;
  - the typedef wb_entry_t {result[63:0], flags[4:0], p, rd[4:0]};
  - the constants CANON_NAN_S and CANON_NAN_D.
- One sub-module, fpadd_wb_fifo: a generic DEPTH-entry FIFO of wb_entry_t with count output.
- The top level holds formatting, the NaN logic and the fflags register.

Test Plan:
- Single push: in_result={40400000,00000000}, p=1, flags=0, rd=3, wb_ready=1. Required: next cycle wb_valid=1, wb_data=FFFFFFFF40400000, wb_rd=3. Cycle after: wb_valid=0, fflags=00000.
- Backpressure: hold wb_ready=0 and push 3 results. Required: count=2 and in_ready=0 after two pushes; the third is held off; wb_data stays constant; fflags stays 0. Release wb_ready: entries drain in order.
- Sticky flags: commit flags 00001 then 10000. Required: fflags=10001. Next, fflags_wr=1 with wdata=00000 in the same cycle as a commit with flags 00100. Required: fflags=00100.
- Pointer wrap: 10 back-to-back push/pop cycles with rd=0..9 and wb_ready=1. Required: wb_rd sequence 0..9, count never exceeds 1, no loss or duplication.
- Reset mid-operation: FIFO full with flags 01000 pending, drive reset=0 for one cycle. Required: count=0, wb_valid=0, fflags=0, in_ready=1.
- FPADD_WB_CANON_NAN_EN:
  - Push f32 7FA00001, p=1. Required: wb_data=FFFFFFFF7FC00000 with macro, FFFFFFFF7FA00001 without.
  - Push double FFF0000000000001, p=0. Required: 7FF8000000000000 with macro.
